// File: rtl/sarray_skew_feeder.sv
// Skew/deskew delay network feeding one systolic-array edge: each lane delays its element plus TMMA metadata
// by a lane-dependent number of advance cycles. Define SARRAY_SKEW_DESKEW_EN to enable reverse (deskew) taps.
module sarray_skew_feeder #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int PREC_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   in_data_i,
  input  logic [CNT_W-1:0]          in_cnt_i,
  input  logic                      in_type_i,
  input  logic [PREC_W-1:0]         in_prec_i,
  input  logic                      in_acc_i,
  input  logic                      advance_i,
  input  logic                      flush_i,
  input  logic                      mode_i,
  output logic                      busy_o,
  output logic [LANES-1:0]          out_valid_o,
  output logic [LANES*DATA_W-1:0]   out_data_o,
  output logic [LANES*CNT_W-1:0]    out_cnt_o,
  output logic [LANES-1:0]          out_type_o,
  output logic [LANES*PREC_W-1:0]   out_prec_o,
  output logic [LANES-1:0]          out_acc_o
);

  localparam int ELEM_W   = DATA_W + CNT_W + PREC_W + 2;
  localparam int CNT_BITS = $clog2(LANES + 1);

  logic                accept;
  logic                deep_vld;
  logic                mode_d, mode_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q;
  logic [LANES-1:0]    tap_vld;
  logic [ELEM_W-1:0]   tap_elem [LANES];

  assign in_ready_o = advance_i & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign busy_o     = (cnt_q != '0);

  // The deepest lane's tap is the last copy of a beat to leave the network.
  assign deep_vld = mode_q ? tap_vld[0] : tap_vld[LANES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (accept && !(advance_i && deep_vld)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end else if (!accept && advance_i && deep_vld) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end
  end

`ifdef SARRAY_SKEW_DESKEW_EN
  // Direction may only change once the network is empty.
  always_comb begin
    mode_d = mode_q;
    if ((cnt_q == '0) && !accept) begin
      mode_d = mode_i;
    end
  end
`else
  logic mode_unused;
  assign mode_unused = mode_i;
  assign mode_d      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef SARRAY_SKEW_DESKEW_EN
    // Only as deep as the furthest of this lane's two taps.
    localparam int DEPTH = ((l > (LANES - 1 - l)) ? l : (LANES - 1 - l)) + 1;
`else
    localparam int DEPTH = l + 1;
`endif
    localparam int VW = DEPTH * ELEM_W;

    logic [DEPTH-1:0]  vld_d, vld_q;
    logic [VW-1:0]     elem_d, elem_q;
    logic [ELEM_W-1:0] in_elem;

    assign in_elem = {in_acc_i, in_prec_i, in_type_i, in_cnt_i, in_data_i[l*DATA_W +: DATA_W]};

    always_comb begin
      vld_d  = vld_q;
      elem_d = elem_q;
      if (flush_i) begin
        vld_d = '0;
      end else if (advance_i) begin
        vld_d  = (vld_q << 1) | DEPTH'(accept);
        elem_d = (elem_q << ELEM_W) | VW'(in_elem);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= '0;
        elem_q <= '0;
      end else begin
        vld_q  <= vld_d;
        elem_q <= elem_d;
      end
    end

`ifdef SARRAY_SKEW_DESKEW_EN
    assign tap_vld[l]  = mode_q ? vld_q[LANES-1-l] : vld_q[l];
    assign tap_elem[l] = mode_q ? elem_q[(LANES-1-l)*ELEM_W +: ELEM_W] : elem_q[l*ELEM_W +: ELEM_W];
`else
    assign tap_vld[l]  = vld_q[l];
    assign tap_elem[l] = elem_q[l*ELEM_W +: ELEM_W];
`endif
  end

  always_comb begin
    out_valid_o = tap_vld;
    out_data_o  = '0;
    out_cnt_o   = '0;
    out_type_o  = '0;
    out_prec_o  = '0;
    out_acc_o   = '0;
    for (int l = 0; l < LANES; l++) begin
      out_data_o[l*DATA_W +: DATA_W] = tap_elem[l][DATA_W-1:0];
      out_cnt_o[l*CNT_W +: CNT_W]    = tap_elem[l][DATA_W +: CNT_W];
      out_type_o[l]                  = tap_elem[l][DATA_W+CNT_W];
      out_prec_o[l*PREC_W +: PREC_W] = tap_elem[l][DATA_W+CNT_W+1 +: PREC_W];
      out_acc_o[l]                   = tap_elem[l][ELEM_W-1];
    end
  end

endmodule

// File: tb/tb_sarray_skew_feeder.sv
// Bench for sarray_skew_feeder (LANES=4, DATA_W=8): per-lane scoreboard queues plus explicit wavefront timing.
module tb_sarray_skew_feeder;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int PREC_W = 2;
  localparam int EW     = DATA_W + CNT_W + PREC_W + 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid_i = 1'b0;
  logic                    in_ready_o;
  logic [LANES*DATA_W-1:0] in_data_i = '0;
  logic [CNT_W-1:0]        in_cnt_i = '0;
  logic                    in_type_i = 1'b0;
  logic [PREC_W-1:0]       in_prec_i = '0;
  logic                    in_acc_i = 1'b0;
  logic                    advance_i = 1'b1;
  logic                    flush_i = 1'b0;
  logic                    mode_i = 1'b0;
  logic                    busy_o;
  logic [LANES-1:0]        out_valid_o;
  logic [LANES*DATA_W-1:0] out_data_o;
  logic [LANES*CNT_W-1:0]  out_cnt_o;
  logic [LANES-1:0]        out_type_o;
  logic [LANES*PREC_W-1:0] out_prec_o;
  logic [LANES-1:0]        out_acc_o;

  sarray_skew_feeder #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W), .PREC_W(PREC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_cnt_i(in_cnt_i), .in_type_i(in_type_i), .in_prec_i(in_prec_i),
    .in_acc_i(in_acc_i), .advance_i(advance_i), .flush_i(flush_i), .mode_i(mode_i),
    .busy_o(busy_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_cnt_o(out_cnt_o),
    .out_type_o(out_type_o), .out_prec_o(out_prec_o), .out_acc_o(out_acc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb [LANES][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] lane_out(input int l);
    return {out_acc_o[l], out_prec_o[l*PREC_W +: PREC_W], out_type_o[l],
            out_cnt_o[l*CNT_W +: CNT_W], out_data_o[l*DATA_W +: DATA_W]};
  endfunction

  task automatic sb_clear();
    for (int l = 0; l < LANES; l++) sb[l].delete();
  endtask

  // A tap beat is consumed by the array on an edge with advance and no flush.
  initial forever begin
    @(negedge clk);
    if (rst_n && advance_i && !flush_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (out_valid_o[l]) begin
          if (sb[l].size() == 0) chk($sformatf("lane%0d_unexpected_beat", l), 1, 0);
          else chk($sformatf("lane%0d_beat", l), lane_out(l), sb[l].pop_front());
        end
      end
    end
  end

  // One clock of stimulus, starting and ending 1 time unit after a rising edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [7:0] c,
                     input logic t, input logic [1:0] p, input logic a);
    logic acc_exp;
    in_valid_i = v; in_data_i = d; in_cnt_i = c; in_type_i = t; in_prec_i = p; in_acc_i = a;
    acc_exp = advance_i & ~flush_i;
    #1;
    chk("in_ready", in_ready_o, acc_exp);
    @(posedge clk);
    if (v && acc_exp)
      for (int l = 0; l < LANES; l++) sb[l].push_back({a, p, t, c, d[l*DATA_W +: DATA_W]});
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 8'h0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    logic pending;
    pending = 1'b1;
    while (pending && n < 50) begin
      pending = busy_o;
      for (int l = 0; l < LANES; l++) if (sb[l].size() != 0) pending = 1'b1;
      if (pending) begin
        @(posedge clk); #1; n++;
      end
    end
    chk({tag, "_drained_in_time"}, (n < 50), 1);
    for (int l = 0; l < LANES; l++) chk($sformatf("%s_lane%0d_left", tag, l), sb[l].size(), 0);
  endtask

  // Single row, then check each cycle's valid pattern, tap data/cnt and busy.
  task automatic wavefront(input string tag, input bit deskew, input bit flip,
                           input logic [31:0] d, input logic [7:0] c);
    logic [3:0] exp_v;
    int lane;
    cyc(1'b1, d, c, 1'b1, 2'b10, 1'b1);
    if (flip) mode_i = ~mode_i;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        exp_v = deskew ? (4'b1000 >> (k - 1)) : (4'b0001 << (k - 1));
        lane  = deskew ? (4 - k) : (k - 1);
        chk($sformatf("%s_data_c%0d", tag, k), out_data_o[lane*DATA_W +: DATA_W], d[lane*DATA_W +: DATA_W]);
        chk($sformatf("%s_cnt_c%0d", tag, k), out_cnt_o[lane*CNT_W +: CNT_W], c);
      end else begin
        exp_v = 4'b0000;
      end
      chk($sformatf("%s_vld_c%0d", tag, k), out_valid_o, exp_v);
      chk($sformatf("%s_busy_c%0d", tag, k), busy_o, (k <= 4));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [35:0] snap;
    int n, c;

    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_cnt", out_cnt_o, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid_o, 0);
    chk("post_rst_busy", busy_o, 0);

    // Single row wavefront.
    wavefront("t1", 1'b0, 1'b0, 32'h44332211, 8'd5);
    drain("t1");

    // Back-to-back rows; busy drops 4 cycles after last accept.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, $urandom, 8'(i + 10), 1'(i), 2'(i), 1'(i >> 1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_busy_c%0d", k), busy_o, (k <= 4));
    end
    @(posedge clk); #1;
    drain("t2");

    // Stall in the middle of a stream.
    n = 0; c = 0;
    while (n < 6 && c < 20) begin
      advance_i = !(c >= 2 && c <= 4);
      if (c == 2) snap = {out_valid_o, out_data_o};
      if (c >= 3 && c <= 5) chk($sformatf("t3_frozen_c%0d", c), {out_valid_o, out_data_o}, snap);
      cyc(1'b1, 32'hA0B0C0D0 + 32'(n), 8'(n + 40), 1'b0, 2'b11, 1'b0);
      if (advance_i) n++;
      c++;
    end
    advance_i = 1'b1;
    chk("t3_all_rows_accepted", n, 6);
    drain("t3");

    // Flush with three rows in flight; flush-cycle row is dropped.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h01020304 * (i + 1), 8'(i + 60), 1'b1, 2'b01, 1'b1);
    flush_i = 1'b1;
    cyc(1'b1, 32'hDEADBEEF, 8'hEE, 1'b1, 2'b11, 1'b1);
    flush_i = 1'b0;
    sb_clear();
    @(negedge clk);
    chk("t4_valid_after_flush", out_valid_o, 0);
    chk("t4_busy_after_flush", busy_o, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_quiet_%0d", k), out_valid_o, 0);
    end
    @(posedge clk); #1;

`ifdef SARRAY_SKEW_DESKEW_EN
    mode_i = 1'b1;
    idle(1);
    wavefront("t5_deskew", 1'b1, 1'b0, 32'h88776655, 8'd7);
    wavefront("t5_hold", 1'b1, 1'b1, 32'h0F0E0D0C, 8'd9);
    wavefront("t5_back_to_skew", 1'b0, 1'b0, 32'h13243546, 8'd3);
`else
    mode_i = 1'b1;
    idle(1);
    wavefront("t5_mode_ignored", 1'b0, 1'b0, 32'h88776655, 8'd7);
    mode_i = 1'b0;
`endif
    drain("t5");

    // Reset pulse mid-stream.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h55AA55AA ^ i, 8'(i + 80), 1'b0, 2'b10, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_in_rst", out_valid_o, 0);
    chk("t6_busy_in_rst", busy_o, 0);
    chk("t6_data_in_rst", out_data_o, 0);
    sb_clear();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_valid_after_rst", out_valid_o, 0);
    wavefront("t6", 1'b0, 1'b0, 32'h44332211, 8'd5);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
